// File: rtl/huc6270_pkg.sv
// Shared types and constants for the background tile fetch path.
package huc6270_pkg;

    localparam int VRAM_AW        = 16;
    localparam int PLANE23_OFFSET = 8;

    typedef struct packed {
        logic [3:0]  palette;
        logic [11:0] tile;
    } bat_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        BAT,
        P01,
        P23,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/bg_fetch_addr_gen.sv
// Combinational VRAM address generation for BAT entries and pattern rows.
module bg_fetch_addr_gen #(
    parameter int AW    = huc6270_pkg::VRAM_AW,
    parameter int CNT_W = 7
) (
    input  logic [AW-1:0]    bat_base,
    input  logic [CNT_W-1:0] col_start,
    input  logic [CNT_W-1:0] col_mask,
    input  logic [CNT_W-1:0] k,
    input  logic [2:0]       tile_row,
    input  logic [11:0]      tile,
    input  logic             hi_planes,
    output logic [AW-1:0]    bat_addr,
    output logic [AW-1:0]    pat_addr
);
    import huc6270_pkg::*;

    logic [CNT_W-1:0] col_idx;
    logic [AW-1:0]    pat_base;

    always_comb begin
        // Column wraps inside the BAT row before being added to the row base.
        col_idx  = (col_start + k) & col_mask;
        bat_addr = bat_base + AW'(col_idx);
        pat_base = AW'({tile, 4'b0000}) + AW'(tile_row);
        pat_addr = hi_planes ? (pat_base + AW'(PLANE23_OFFSET)) : pat_base;
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Fetches BAT entries and two pattern words per tile, emitting one packed
// four-plane beat per tile over a valid/ready interface.
module bg_tile_fetcher #(
    parameter int VRAM_AW = huc6270_pkg::VRAM_AW,
    parameter int CNT_W   = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [VRAM_AW-1:0] bat_base_addr,
    input  logic [CNT_W-1:0]   bat_col_start,
    input  logic [CNT_W-1:0]   bat_col_mask,
    input  logic [2:0]         tile_row,
    input  logic [CNT_W-1:0]   num_tiles,
    output logic               vram_req,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_ack,
    input  logic [15:0]        vram_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_line_bytes,
    output logic [3:0]         out_palette,
    output logic               out_last,
    output logic               busy,
    output logic               done
);
    import huc6270_pkg::*;

    fetch_state_t       state_q, state_d;
    logic [VRAM_AW-1:0] base_q, base_d;
    logic [CNT_W-1:0]   col_q, col_d, mask_q, mask_d, num_q, num_d, k_q, k_d;
    logic [2:0]         row_q, row_d;
    logic [11:0]        tile_q, tile_d;
    logic [3:0]         pal_q, pal_d, stage_pal_q, stage_pal_d, out_pal_q, out_pal_d;
    logic [15:0]        p01_q, p01_d;
    logic [31:0]        stage_bytes_q, stage_bytes_d, out_bytes_q, out_bytes_d;
    logic               stage_last_q, stage_last_d, out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d, done_q, done_d;

    logic [VRAM_AW-1:0] bat_addr, pat_addr;
    logic               out_free, is_last;
    bat_entry_t         bat_word;

    bg_fetch_addr_gen #(.AW(VRAM_AW), .CNT_W(CNT_W)) u_addr_gen (
        .bat_base  (base_q),
        .col_start (col_q),
        .col_mask  (mask_q),
        .k         (k_q),
        .tile_row  (row_q),
        .tile      (tile_q),
        .hi_planes (state_q == P23),
        .bat_addr  (bat_addr),
        .pat_addr  (pat_addr)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        col_d         = col_q;
        mask_d        = mask_q;
        num_d         = num_q;
        k_d           = k_q;
        row_d         = row_q;
        tile_d        = tile_q;
        pal_d         = pal_q;
        p01_d         = p01_q;
        stage_bytes_d = stage_bytes_q;
        stage_pal_d   = stage_pal_q;
        stage_last_d  = stage_last_q;
        out_bytes_d   = out_bytes_q;
        out_pal_d     = out_pal_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        done_d        = 1'b0;
        vram_req      = 1'b0;
        vram_addr     = '0;
        bat_word      = bat_entry_t'(vram_rdata);

        // The output register can take a new beat if empty or draining this cycle.
        out_free = !out_valid_q || out_ready;
        is_last  = (k_q == num_q - CNT_W'(1));
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_tiles != '0) begin
                        base_d  = bat_base_addr;
                        col_d   = bat_col_start;
                        mask_d  = bat_col_mask;
                        row_d   = tile_row;
                        num_d   = num_tiles;
                        k_d     = '0;
                        state_d = BAT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BAT: begin
                vram_req  = 1'b1;
                vram_addr = bat_addr;
                if (vram_ack) begin
                    tile_d  = bat_word.tile;
                    pal_d   = bat_word.palette;
                    state_d = P01;
                end
            end
            P01: begin
                vram_req  = 1'b1;
                vram_addr = pat_addr;
                if (vram_ack) begin
                    p01_d   = vram_rdata;
                    state_d = P23;
                end
            end
            P23: begin
                vram_req  = 1'b1;
                vram_addr = pat_addr;
                if (vram_ack) begin
                    if (out_free) begin
                        out_bytes_d = {vram_rdata, p01_q};
                        out_pal_d   = pal_q;
                        out_last_d  = is_last;
                        out_valid_d = 1'b1;
                        k_d         = k_q + CNT_W'(1);
                        state_d     = is_last ? DRAIN : BAT;
                    end else begin
                        stage_bytes_d = {vram_rdata, p01_q};
                        stage_pal_d   = pal_q;
                        stage_last_d  = is_last;
                        state_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_bytes_d = stage_bytes_q;
                    out_pal_d   = stage_pal_q;
                    out_last_d  = stage_last_q;
                    out_valid_d = 1'b1;
                    k_d         = k_q + CNT_W'(1);
                    state_d     = stage_last_q ? DRAIN : BAT;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            col_q         <= '0;
            mask_q        <= '0;
            num_q         <= '0;
            k_q           <= '0;
            row_q         <= '0;
            tile_q        <= '0;
            pal_q         <= '0;
            p01_q         <= '0;
            stage_bytes_q <= '0;
            stage_pal_q   <= '0;
            stage_last_q  <= 1'b0;
            out_bytes_q   <= '0;
            out_pal_q     <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            col_q         <= col_d;
            mask_q        <= mask_d;
            num_q         <= num_d;
            k_q           <= k_d;
            row_q         <= row_d;
            tile_q        <= tile_d;
            pal_q         <= pal_d;
            p01_q         <= p01_d;
            stage_bytes_q <= stage_bytes_d;
            stage_pal_q   <= stage_pal_d;
            stage_last_q  <= stage_last_d;
            out_bytes_q   <= out_bytes_d;
            out_pal_q     <= out_pal_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            done_q        <= done_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_line_bytes = out_bytes_q;
    assign out_palette    = out_pal_q;
    assign out_last       = out_last_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Self-checking bench: VRAM model with wait states, scoreboard of expected
// addresses and beats, table of runs plus backpressure and reset sequences.
module tb_bg_tile_fetcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bat_base_addr = '0;
    logic [6:0]  bat_col_start = '0;
    logic [6:0]  bat_col_mask = 7'd31;
    logic [2:0]  tile_row = '0;
    logic [6:0]  num_tiles = '0;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [15:0] vram_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_line_bytes;
    logic [3:0]  out_palette;
    logic        out_last;
    logic        busy;
    logic        done;

    bg_tile_fetcher dut (
        .clock(clock), .reset(reset), .start(start),
        .bat_base_addr(bat_base_addr), .bat_col_start(bat_col_start),
        .bat_col_mask(bat_col_mask), .tile_row(tile_row), .num_tiles(num_tiles),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_line_bytes(out_line_bytes), .out_palette(out_palette),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] bytes;
        logic [3:0]  pal;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] base;
        logic [6:0]  col;
        logic [6:0]  mask;
        logic [2:0]  row;
        logic [6:0]  num;
        int          wait_c;
        int          exp_done;
        bit          inject;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_cycles = 0;
    int          acc_cnt = 0;
    int          ack_count = 0;
    logic [15:0] acc_addr = '0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_addr [$];
    beat_t       exp_beats [$];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] vram_data(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC5};
    endfunction

    task automatic expect_run(input logic [15:0] base, input logic [6:0] col,
                              input logic [6:0] mask, input logic [2:0] row,
                              input logic [6:0] num);
        for (int k = 0; k < int'(num); k++) begin
            logic [6:0]  c;
            logic [15:0] ba, pa, bat, p01, p23;
            c   = (col + 7'(k)) & mask;
            ba  = base + {9'd0, c};
            bat = vram_data(ba);
            pa  = {bat[11:0], 4'd0} + {13'd0, row};
            p01 = vram_data(pa);
            p23 = vram_data(pa + 16'd8);
            exp_addr.push_back(ba);
            exp_addr.push_back(pa);
            exp_addr.push_back(pa + 16'd8);
            exp_beats.push_back('{{p23, p01}, bat[15:12], (k == int'(num) - 1)});
        end
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [6:0] col,
                               input logic [6:0] mask, input logic [2:0] row,
                               input logic [6:0] num);
        @(posedge clock); #1;
        bat_base_addr = base; bat_col_start = col; bat_col_mask = mask;
        tile_row = row; num_tiles = num; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // VRAM: acks after wait_cycles idle request cycles, data in the ack cycle.
    initial begin
        forever begin
            @(posedge clock); #2;
            if (vram_req) begin
                if (acc_cnt == 0) acc_addr = vram_addr;
                else check("vram_addr_stable", vram_addr, acc_addr);
                if (acc_cnt == wait_cycles) begin
                    vram_ack   = 1'b1;
                    vram_rdata = vram_data(vram_addr);
                    ack_count++;
                    if (exp_addr.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL vram_unexpected_req: addr 0x%0h, required no request", vram_addr);
                    end else begin
                        check("vram_addr", vram_addr, exp_addr.pop_front());
                    end
                    acc_cnt = 0;
                end else begin
                    vram_ack = 1'b0;
                    acc_cnt++;
                end
            end else begin
                vram_ack = 1'b0;
                acc_cnt  = 0;
            end
        end
    end

    // Output scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (exp_beats.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL beat_unexpected: bytes 0x%08h, required no beat", out_line_bytes);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_bytes", out_line_bytes, b.bytes);
                    check("beat_palette", {28'd0, out_palette}, {28'd0, b.pal});
                    check("beat_last", {31'd0, out_last}, {31'd0, b.last});
                    $display("beat bytes=0x%08h pal=%0d last=%0d", out_line_bytes, out_palette, out_last);
                end
            end
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc;
        v = vecs[idx];
        wait_cycles = v.wait_c;
        out_ready   = 1'b1;
        expect_run(v.base, v.col, v.mask, v.row, v.num);
        @(posedge clock); #1;
        bat_base_addr = v.base; bat_col_start = v.col; bat_col_mask = v.mask;
        tile_row = v.row; num_tiles = v.num; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            @(negedge clock);
            if (cyc == 1) begin
                check("busy_after_start", {31'd0, busy}, {31'd0, v.num != 0});
                if (v.num == 0) check("num0_no_req", {31'd0, vram_req}, 32'd0);
            end
            if (done) break;
            @(posedge clock); #1;
            cyc++;
            if (v.inject && cyc == 2) begin
                start = 1'b1; num_tiles = 7'd5; bat_base_addr = 16'h3333; tile_row = 3'd5;
            end else begin
                start = 1'b0;
            end
        end
        check("done_cycle", cyc, v.exp_done);
        @(posedge clock); #1;
        @(negedge clock);
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("beats_outstanding", exp_beats.size(), 0);
        check("addrs_outstanding", exp_addr.size(), 0);
        $display("run %0d base=0x%04h col=%0d num=%0d wait=%0d done_cycle=%0d",
                 idx, v.base, v.col, v.num, v.wait_c, cyc);
    endtask

    initial begin
        int cyc;
        int acks0;

        mem[16'h0000] = 16'h5123;
        mem[16'h1233] = 16'hAA55;
        mem[16'h123B] = 16'h0FF0;

        vecs[0] = '{16'h0000, 7'd0,  7'd127, 3'd3, 7'd1, 0, 5,  1'b0};
        vecs[1] = '{16'h0200, 7'd30, 7'd31,  3'd0, 7'd4, 0, 14, 1'b0};
        vecs[2] = '{16'h1000, 7'd5,  7'd63,  3'd6, 7'd2, 3, 26, 1'b0};
        vecs[3] = '{16'h0100, 7'd0,  7'd31,  3'd0, 7'd0, 0, 1,  1'b0};
        vecs[4] = '{16'h0400, 7'd10, 7'd31,  3'd1, 7'd2, 0, 8,  1'b1};
        vecs[5] = '{16'hFFFE, 7'd62, 7'd63,  3'd7, 7'd5, 0, 17, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_vram_req", {31'd0, vram_req}, 32'd0);
        check("rst_vram_addr", {16'd0, vram_addr}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_bytes", out_line_bytes, 32'd0);
        check("rst_out_palette", {28'd0, out_palette}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure: consumer stalls for 12 cycles during a 3-tile run.
        wait_cycles = 0;
        out_ready   = 1'b0;
        expect_run(16'h0800, 7'd3, 7'd31, 3'd2, 7'd3);
        acks0 = ack_count;
        pulse_start(16'h0800, 7'd3, 7'd31, 3'd2, 7'd3);
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (cyc >= 4) check("bp_beat1_valid", {31'd0, out_valid}, 32'd1);
            if (out_valid) check("bp_beat1_stable", out_line_bytes, exp_beats[0].bytes);
            if (cyc >= 7) check("bp_hold_no_req", {31'd0, vram_req}, 32'd0);
            if (cyc < 12) begin
                @(posedge clock); #1;
            end
        end
        check("bp_acks_during_stall", ack_count - acks0, 6);
        @(posedge clock); #1;
        out_ready = 1'b1;
        cyc = 13;
        while (cyc < 500) begin
            @(negedge clock);
            if (done) break;
            @(posedge clock); #1;
            cyc++;
        end
        check("bp_done_cycle", cyc, 18);
        check("bp_beats_outstanding", exp_beats.size(), 0);
        $display("run backpressure done_cycle=%0d", cyc);

        // Reset while a P01 request is pending with wait states.
        wait_cycles = 3;
        expect_run(16'h0040, 7'd2, 7'd31, 3'd4, 7'd2);
        pulse_start(16'h0040, 7'd2, 7'd31, 3'd4, 7'd2);
        for (cyc = 1; cyc < 6; cyc++) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("p01_req_before_reset", {31'd0, vram_req}, 32'd1);
        check("p01_addr_before_reset", {16'd0, vram_addr}, {16'd0, exp_addr[0]});
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_vram_req", {31'd0, vram_req}, 32'd0);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        exp_addr.delete();
        exp_beats.delete();
        repeat (3) begin
            @(negedge clock);
            check("post_rst_quiet", {31'd0, vram_req | out_valid}, 32'd0);
        end
        $display("run reset_in_p01 complete");
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
